// File: rtl/aes_round_sequencer.sv
// Round-control FSM for the AES-128 core: accept a block, run NR rounds, hand the result to the serializer.
// Optional `STALL_COUNT_EN adds a saturating counter of cycles spent waiting on the serializer.
module aes_round_sequencer #(
    parameter int unsigned NR = 10
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        block_valid,
    input  logic        key_ready,
    input  logic        out_busy,
    output logic        block_ack,
    output logic        load_state,
    output logic        round_en,
    output logic [3:0]  round_idx,
    output logic        first_round,
    output logic        final_round,
    output logic        transformer_done,
    output logic        busy,
    output logic [15:0] stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_HOLD,
        S_DONE
    } state_e;

    localparam logic [3:0] IDX_FINAL     = 4'(NR);
    localparam logic [3:0] IDX_LAST_FULL = 4'(NR - 1);

    state_e     state_q, state_d;
    logic [3:0] round_idx_q, round_idx_d;
    logic       block_ack_q, block_ack_d;
    logic       round_en_q, round_en_d;
    logic       final_round_q, final_round_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        case (state_q)
            S_IDLE: begin
                if (block_valid && key_ready) begin
                    state_d     = S_INIT;
                    round_idx_d = 4'd0;
                end
            end
            S_INIT: begin
                round_idx_d = 4'd1;
                state_d     = (IDX_FINAL == 4'd1) ? S_FINAL : S_ROUND;
            end
            S_ROUND: begin
                round_idx_d = round_idx_q + 4'd1;
                if (round_idx_q == IDX_LAST_FULL) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                state_d = out_busy ? S_HOLD : S_DONE;
            end
            S_HOLD: begin
                if (!out_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                round_idx_d = 4'd0;
            end
            default: begin
                state_d     = S_IDLE;
                round_idx_d = 4'd0;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        block_ack_d   = (state_d == S_INIT);
        round_en_d    = (state_d == S_INIT) || (state_d == S_ROUND) || (state_d == S_FINAL);
        final_round_d = (state_d == S_FINAL);
        done_d        = (state_d == S_DONE);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q       <= S_IDLE;
            round_idx_q   <= 4'd0;
            block_ack_q   <= 1'b0;
            round_en_q    <= 1'b0;
            final_round_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_idx_q   <= round_idx_d;
            block_ack_q   <= block_ack_d;
            round_en_q    <= round_en_d;
            final_round_q <= final_round_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign block_ack        = block_ack_q;
    assign load_state       = block_ack_q;
    assign first_round      = block_ack_q;
    assign round_en         = round_en_q;
    assign round_idx        = round_idx_q;
    assign final_round      = final_round_q;
    assign transformer_done = done_q;
    assign busy             = busy_q;

`ifdef STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_HOLD) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a round-counter reference model.
module tb_aes_round_sequencer;

    localparam int NR     = 10;
    localparam int P_HOLD = NR + 2;
    localparam int P_DONE = NR + 3;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic        block_valid = 1'b0;
    logic        key_ready = 1'b0;
    logic        out_busy = 1'b0;
    logic        block_ack, load_state, round_en, first_round, final_round;
    logic        transformer_done, busy;
    logic [3:0]  round_idx;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    aes_round_sequencer #(.NR(NR)) dut (
        .clk              (clk),
        .rst_             (rst_),
        .block_valid      (block_valid),
        .key_ready        (key_ready),
        .out_busy         (out_busy),
        .block_ack        (block_ack),
        .load_state       (load_state),
        .round_en         (round_en),
        .round_idx        (round_idx),
        .first_round      (first_round),
        .final_round      (final_round),
        .transformer_done (transformer_done),
        .busy             (busy),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: pos = 0 idle, 1..NR+1 = cycle k of a block (round k-1), then hold, then done.
    int          pos = 0;
    logic [15:0] stall_m = 16'h0000;

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pos     <= 0;
            stall_m <= 16'h0000;
        end else begin
`ifdef STALL_COUNT_EN
            if (pos == P_HOLD && stall_m != 16'hFFFF) stall_m <= stall_m + 16'd1;
`endif
            if (pos == 0)
                pos <= (block_valid && key_ready) ? 1 : 0;
            else if (pos <= NR)
                pos <= pos + 1;
            else if (pos == NR + 1 || pos == P_HOLD)
                pos <= out_busy ? P_HOLD : P_DONE;
            else
                pos <= 0;
        end
    end

    function automatic logic [10:0] expected_vec(input int p);
        logic [3:0] idx;
        if (p == 0) idx = 4'd0;
        else if (p <= NR + 1) idx = 4'(p - 1);
        else idx = 4'(NR);
        return {p == 1, p == 1, (p >= 1 && p <= NR + 1), idx, p == 1, p == NR + 1, p == P_DONE, p != 0};
    endfunction

    always @(negedge clk) begin
        logic [10:0] got, exp;
        got = {block_ack, load_state, round_en, round_idx, first_round, final_round, transformer_done, busy};
        exp = expected_vec(pos);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL model_outputs t=%0t got=%b expected=%b", $time, got, exp);
        end
        checks++;
        if (stall_cycles !== stall_m) begin
            errors++;
            $display("FAIL model_stall t=%0t got=%0d expected=%0d", $time, stall_cycles, stall_m);
        end
        checks++;
        if ((first_round && final_round) || round_idx > 4'(NR)) begin
            errors++;
            $display("FAIL invariant t=%0t first=%b final=%b idx=%0d required excl and idx<=%0d",
                     $time, first_round, final_round, round_idx, NR);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        block_valid = 1'b0;
        out_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #1 rst_ = 1'b0;
        #1;
        checks++;
        if ({block_ack, load_state, round_en, round_idx, first_round, final_round,
             transformer_done, busy, stall_cycles} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs got idx=%0d busy=%b done=%b stall=%0d required all 0",
                     round_idx, busy, transformer_done, stall_cycles);
        end
        tick();
        tick();
        rst_ = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_release_idle got busy=%b idx=%0d required 0/0", busy, round_idx);
        end
    endtask

    task automatic test_single_block();
        int ack_cyc = -1, done_cyc = -1;
        bit ok;
        block_valid = 1'b1;
        key_ready = 1'b1;
        out_busy = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (block_ack && ack_cyc < 0) ack_cyc = c;
            if (transformer_done && done_cyc < 0) done_cyc = c;
            if (c == 1) block_valid = 1'b0;
            if (c <= NR + 1) begin
                checks++;
                if (round_idx !== 4'(c - 1)) begin
                    errors++;
                    $display("FAIL single_round_idx cycle=%0d got=%0d required=%0d", c, round_idx, c - 1);
                end
            end
            if (c == 13) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy_end got=%b required=0", busy);
                end
            end
        end
        checks++;
        if (ack_cyc != 1) begin
            errors++;
            $display("FAIL single_ack_cycle got=%0d required=1", ack_cyc);
        end
        checks++;
        if (done_cyc != NR + 2) begin
            errors++;
            $display("FAIL single_done_cycle got=%0d required=%0d", done_cyc, NR + 2);
        end
        drain(ok);
    endtask

    task automatic test_key_wait();
        int bad = 0;
        bit ok;
        block_valid = 1'b1;
        key_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (block_ack || busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL key_wait_no_ack got=%0d bad cycles required=0", bad);
        end
        key_ready = 1'b1;
        tick();
        checks++;
        if (block_ack !== 1'b1) begin
            errors++;
            $display("FAIL key_wait_ack got=%b required=1", block_ack);
        end
        block_valid = 1'b0;
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL key_wait_drain got=busy required=idle");
        end
    endtask

    task automatic test_hold();
        logic [15:0] stall_start;
        int          seen = 0;
        int          bad = 0;
        bit          ok;
        stall_start = stall_cycles;
        block_valid = 1'b1;
        key_ready = 1'b1;
        out_busy = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (block_ack) block_valid = 1'b0;
            if (final_round) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hold_reach_final got=timeout required=final_round");
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (round_en !== 1'b0 || round_idx !== 4'(NR) || busy !== 1'b1 || transformer_done !== 1'b0) bad++;
            if (k == 5) out_busy = 1'b0;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_state got=%0d bad cycles required=0", bad);
        end
        tick();
        checks++;
        if (transformer_done !== 1'b1) begin
            errors++;
            $display("FAIL hold_done got=%b required=1", transformer_done);
        end
        checks++;
`ifdef STALL_COUNT_EN
        if (stall_cycles - stall_start !== 16'd5) begin
`else
        if (stall_cycles - stall_start !== 16'd0) begin
`endif
            errors++;
            $display("FAIL hold_stall_count got=%0d (start %0d)", stall_cycles, stall_start);
        end
        drain(ok);
    endtask

    task automatic test_back_to_back();
        int acks[4];
        int n_ack = 0, n_done = 0;
        bit ok;
        block_valid = 1'b1;
        key_ready = 1'b1;
        out_busy = 1'b0;
        for (int c = 0; c < 80 && n_ack < 4; c++) begin
            tick();
            if (transformer_done && n_ack > 0) n_done++;
            if (block_ack) begin
                acks[n_ack] = c;
                n_ack++;
            end
        end
        checks++;
        if (n_ack != 4) begin
            errors++;
            $display("FAIL b2b_ack_count got=%0d required=4", n_ack);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acks[i] - acks[i-1] != NR + 3) begin
                    errors++;
                    $display("FAIL b2b_spacing idx=%0d got=%0d required=%0d", i, acks[i] - acks[i-1], NR + 3);
                end
            end
        end
        checks++;
        if (n_done != 3) begin
            errors++;
            $display("FAIL b2b_done_count got=%0d required=3", n_done);
        end
        drain(ok);
    endtask

    task automatic test_reset_mid();
        int seen = 0, dones = 0, done_cyc = -1;
        bit ok;
        block_valid = 1'b1;
        key_ready = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (block_ack) block_valid = 1'b0;
            if (round_idx == 4'd6) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_reach_idx6 got=timeout required=round_idx 6");
        end
        rst_ = 1'b0;
        #1;
        checks++;
        if ({block_ack, round_en, round_idx, final_round, transformer_done, busy} !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got idx=%0d busy=%b round_en=%b required 0",
                     round_idx, busy, round_en);
        end
        tick();
        rst_ = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (transformer_done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL mid_reset_no_done got=%0d required=0", dones);
        end
        block_valid = 1'b1;
        for (int c = 1; c <= NR + 3; c++) begin
            tick();
            if (c == 1) block_valid = 1'b0;
            if (transformer_done && done_cyc < 0) done_cyc = c;
        end
        checks++;
        if (done_cyc != NR + 2) begin
            errors++;
            $display("FAIL mid_reset_next_block got=%0d required=%0d", done_cyc, NR + 2);
        end
        drain(ok);
    endtask

    task automatic test_random();
        bit ok;
        for (int c = 0; c < 800; c++) begin
            block_valid = ($urandom_range(0, 3) != 0);
            key_ready   = ($urandom_range(0, 2) != 0);
            out_busy    = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 149) == 0) rst_ = 1'b0;
            tick();
            rst_ = 1'b1;
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL random_drain got=busy required=idle");
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_key_wait();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
